// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   BYTE_W / WORD_W       stream byte and RAM word widths
//   BYTES_PER_WORD, CNT_W bytes per word and width of the byte-lane counter
//   state_t               loader FSM encoding (CKSUM only when IMEM_LOADER_CKSUM_EN)
//   pk_out_t              word_packer result {full pulse, assembled word}
//   be_insert()           big-endian lane mapping: lane k -> bits [31-8k -: 8]
// Optional feature macro: IMEM_LOADER_CKSUM_EN (adds the trailing checksum word).
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic              full;  // pulses with the byte that completes a word
    logic [WORD_W-1:0] word;  // word including the byte being pushed
  } pk_out_t;

  // First byte of a word is the most significant one.
  function automatic logic [WORD_W-1:0] be_insert(input logic [WORD_W-1:0] w,
                                                  input logic [CNT_W-1:0]  lane,
                                                  input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (lane == CNT_W'(i)) r[WORD_W-BYTE_W*(i+1) +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: assembles big-endian 32-bit words from a byte stream.
//   clk, reset  clock / async active-high reset
//   clear       drop any partial word (start of a session)
//   push        a byte is accepted this cycle
//   din         accepted byte
//   pk          {full, word}: full pulses combinationally with the 4th byte,
//               word already contains that byte so the caller can register it.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  output pk_out_t           pk
);

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;

  always_comb begin
    acc_nxt = be_insert(acc, cnt, din);
    pk.full = push && (cnt == CNT_W'(BYTES_PER_WORD-1));
    pk.word = acc_nxt;
  end

  // The lane counter wraps to 0 after the last lane, so the next word starts
  // clean; every lane is overwritten before the next full pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (push) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: zero-fills the instruction RAM, then loads a program from a
// byte stream, packing big-endian words written at ascending word addresses.
// The core is held in cpu_stall for the whole session.
// Optional feature macro: IMEM_LOADER_CKSUM_EN -- after the last word a 4-byte
// checksum word is received and compared to the mod-2^32 sum of all words.
// Ports:
//   clk, reset          clock / async active-high reset
//   start               begin a session (honoured in IDLE/DONE only)
//   byte_valid/data     input byte stream
//   byte_ready          loader accepts a byte this cycle (RECV/CKSUM)
//   we, wa, wd          registered RAM write port; wa/wd hold when we=0
//   cpu_stall           high while a session is in progress
//   done                session complete, held until next start or reset
//   err                 checksum mismatch (constant 0 without the feature)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int NUM_WORDS = 64
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [WORD_W-1:0] wd,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS-1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;         // clear address in CLEAR, word index afterwards
  logic              accept;
  logic              begin_load;
  pk_out_t           pk;

  assign accept     = byte_valid && byte_ready;
  assign begin_load = start && (state == S_IDLE || state == S_DONE);

  word_packer u_pack (
    .clk   (clk),
    .reset (reset),
    .clear (begin_load),
    .push  (accept),
    .din   (byte_data),
    .pk    (pk)
  );

  // Outputs are registered together with the state, so each one already
  // reflects the state being entered on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      byte_ready <= 1'b0;
      cpu_stall  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_CLEAR;
            cnt       <= '0;
            we        <= 1'b1;
            wa        <= '0;
            wd        <= '0;
            cpu_stall <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state      <= S_RECV;
            cnt        <= '0;
            we         <= 1'b0;
            byte_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            wa  <= cnt + 1'b1;
          end
        end
        S_RECV: begin
          if (pk.full) begin
            state      <= S_WRITE;
            we         <= 1'b1;
            wa         <= cnt;
            wd         <= pk.word;
            byte_ready <= 1'b0;
          end
        end
        S_WRITE: begin
          we <= 1'b0;
          if (cnt == LAST) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state      <= S_CKSUM;
            byte_ready <= 1'b1;
`else
            state     <= S_DONE;
            cpu_stall <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            state      <= S_RECV;
            cnt        <= cnt + 1'b1;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (pk.full) begin
            state      <= S_DONE;
            byte_ready <= 1'b0;
            cpu_stall  <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  // Running sum accumulates the word sitting on wd during each WRITE cycle.
  logic [WORD_W-1:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
      err <= 1'b0;
    end else if (begin_load) begin
      sum <= '0;
      err <= 1'b0;
    end else if (state == S_WRITE) begin
      sum <= sum + wd;
    end else if (state == S_CKSUM && pk.full) begin
      err <= (pk.word != sum);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (NUM_WORDS=4): table-driven sessions, hand-written
// corner sequences (async reset mid-RECV, start during RECV/DONE, checksum),
// and random streams checked against a byte-list packing model.
module tb_imem_loader;

  localparam int AW = 6;
  localparam int NW = 4;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam int CK_CYC = 4;
`else
  localparam int CK_CYC = 0;
`endif
  localparam int STALL_CONT = NW + 5*NW + CK_CYC;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, we, cpu_stall, done, err;
  logic [AW-1:0] wa;
  logic [31:0]   wd;

  imem_loader #(.ADDR_W(AW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .wa(wa),
    .wd(wd), .cpu_stall(cpu_stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t        wlog[$];
  int         stall_cycles;
  logic [7:0] sbytes[$];

  // Write monitor: log every RAM write; a write cycle must never offer ready.
  always @(negedge clk) begin
    if (!reset) begin
      if (we) begin
        wlog.push_back(wr_t'{a: wa, d: wd});
        chk("ready_in_write", byte_ready, 1'b0);
        chk("stall_in_write", cpu_stall, 1'b1);
      end
      if (cpu_stall) stall_cycles++;
      if (done) chk("done_vs_stall", cpu_stall, 1'b0);
    end
  end

  // Reference model: word w is bytes 4w..4w+3, first byte most significant.
  function automatic logic [31:0] pack_word(input int w);
    logic [31:0] r;
    r = 0;
    for (int k = 0; k < 4; k++) r = r + (32'(sbytes[4*w+k]) << (24 - 8*k));
    return r;
  endfunction

  task automatic append_word(input logic [31:0] c);
    for (int k = 0; k < 4; k++) sbytes.push_back(8'(c >> (24 - 8*k)));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid
  task automatic stream(input int from, input int to, input int mode);
    int i = from;
    int guard = 0;
    while (i < to && guard < 2000) begin
      @(negedge clk);
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (guard % 2 == 0);
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_data = sbytes[i];
      if (byte_valid && byte_ready) i++;
      guard++;
    end
    @(negedge clk); byte_valid = 1'b0;
    if (i < to) chk("stream_budget", 64'(i), 64'(to));
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 500) begin @(negedge clk); g++; end
    chk("done_timeout", done, 1'b1);
  endtask

  task automatic check_log(input string tag, input logic [31:0] ew[NW]);
    wr_t e;
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(2*NW));
    for (int i = 0; i < 2*NW && i < wlog.size(); i++) begin
      e.a = AW'(i % NW);
      e.d = (i < NW) ? 32'h0 : ew[i-NW];
      chk($sformatf("%s_wr%0d", tag, i), wlog[i], e);
    end
  endtask

  task automatic run_session(input string tag, input int mode, input logic [31:0] ew[NW],
                             input int est, input logic eerr);
    wlog.delete();
    stall_cycles = 0;
    pulse_start();
    stream(0, sbytes.size(), mode);
    wait_done();
    check_log(tag, ew);
    if (est >= 0) chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(est));
    chk({tag, "_err"}, err, eerr);
    chk({tag, "_stall_low"}, cpu_stall, 1'b0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  base;
    int          mode;
    logic [31:0] w[NW];
    int          stall;
  } vec_t;

  vec_t tbl[4];

  task automatic set_row(input int i, input string n, input logic [7:0] b, input int m,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input int st);
    tbl[i].name = n; tbl[i].base = b; tbl[i].mode = m;
    tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2; tbl[i].w[3] = w3;
    tbl[i].stall = st;
  endtask

  task automatic load_seq(input logic [7:0] base, input logic [31:0] ew[NW]);
    logic [31:0] s;
    s = 0;
    sbytes.delete();
    for (int j = 0; j < 4*NW; j++) sbytes.push_back(8'(base + 8'(j)));
    for (int w = 0; w < NW; w++) s = s + ew[w];
`ifdef IMEM_LOADER_CKSUM_EN
    append_word(s);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seqw[NW];
    logic [31:0] ew[NW];
    logic [31:0] s;
    logic        eerr;

    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #1 reset = 1'b1;
    #2 chk("reset_outputs", {we, wa, wd, byte_ready, cpu_stall, done, err}, 64'h0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {we, byte_ready, cpu_stall, done}, 64'h0);

    set_row(0, "seq_cont",    8'h00, 0, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, STALL_CONT);
    set_row(1, "seq_toggle",  8'h00, 1, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, -1);
    set_row(2, "hi_cont",     8'hF0, 0, 32'hF0F1F2F3, 32'hF4F5F6F7, 32'hF8F9FAFB, 32'hFCFDFEFF, STALL_CONT);
    set_row(3, "wrap_toggle", 8'hF8, 1, 32'hF8F9FAFB, 32'hFCFDFEFF, 32'h00010203, 32'h04050607, -1);
    seqw = tbl[0].w;

    // Async reset after two bytes of the first word; stale bytes must vanish.
    sbytes.delete(); sbytes.push_back(8'hAA); sbytes.push_back(8'hBB);
    pulse_start();
    stream(0, 2, 0);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", {we, wa, wd, byte_ready, cpu_stall, done, err}, 64'h0);
    @(negedge clk); reset = 1'b0;
    load_seq(8'h00, seqw);
    run_session("after_reset", 0, seqw, STALL_CONT, 1'b0);

    for (int r = 0; r < 4; r++) begin
      load_seq(tbl[r].base, tbl[r].w);
      run_session(tbl[r].name, tbl[r].mode, tbl[r].w, tbl[r].stall, 1'b0);
    end

    // start during RECV is ignored: no second clear pass appears in the log.
    load_seq(8'h00, seqw);
    wlog.delete();
    pulse_start();
    stream(0, 6, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    stream(6, sbytes.size(), 0);
    wait_done();
    check_log("start_in_recv", seqw);

    // DONE ignores the stream and holds done.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); byte_valid = 1'b1; byte_data = 8'h5A;
      chk("done_ready_low", byte_ready, 1'b0);
    end
    @(negedge clk); byte_valid = 1'b0;
    chk("done_held", done, 1'b1);
    chk("done_no_writes", 64'(wlog.size()), 64'(2*NW));

    // start in DONE: done drops and clearing restarts at word 0.
    pulse_start();
    chk("restart_state", {done, we, wa, wd, cpu_stall}, {1'b0, 1'b1, {AW{1'b0}}, 32'h0, 1'b1});
    stream(0, sbytes.size(), 0);
    wait_done();

`ifdef IMEM_LOADER_CKSUM_EN
    for (int w = 0; w < NW; w++) ew[w] = 32'(w + 1);
    sbytes.delete();
    for (int w = 0; w < NW; w++) append_word(ew[w]);
    append_word(32'h0000000A);
    run_session("cksum_good", 0, ew, STALL_CONT, 1'b0);
    sbytes.delete();
    for (int w = 0; w < NW; w++) append_word(ew[w]);
    append_word(32'h0000000B);
    run_session("cksum_bad", 0, ew, STALL_CONT, 1'b1);
    pulse_start();
    chk("err_cleared_on_start", err, 1'b0);
    stream(0, sbytes.size(), 0);
    wait_done();
`endif

    // Random programs and random valid patterns against the packing model.
    for (int sidx = 0; sidx < 6; sidx++) begin
      eerr = 1'b0;
      s = 0;
      sbytes.delete();
      for (int j = 0; j < 4*NW; j++) sbytes.push_back(8'($urandom));
      for (int w = 0; w < NW; w++) begin ew[w] = pack_word(w); s = s + ew[w]; end
`ifdef IMEM_LOADER_CKSUM_EN
      if ($urandom_range(0, 1) == 1) append_word(s);
      else begin
        append_word(s ^ (32'h1 << $urandom_range(0, 31)));
        eerr = 1'b1;
      end
`endif
      run_session($sformatf("rnd%0d", sidx), 2, ew, -1, eerr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
